// File: rtl/core_pkg.sv
// Shared definitions for the riscv_core R-type execution core.
// Contents:
//   - datapath sizes (XLEN, register count, register address width)
//   - RV32I R-type opcode and funct3/funct7 constants
//   - 4-bit ALU op codes (alu_op_e) and the decoded-instruction struct
//   - FSM state encoding (core_state_e)
//   - power-estimator weights
//   - decode_rtype(): opcode/funct -> {legal, op}
//   - op_weight(): activity weight of an ALU op for the power estimate
package core_pkg;

   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam int NUM_ALU_OPS = 10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EXEC     = 2'd1,
      ST_WB       = 2'd2,
      ST_WAIT_LOW = 2'd3
   } core_state_e;

   typedef struct packed {
      logic    legal;
      alu_op_e op;
   } decode_t;

   // Power estimate = base + OPCODE_WEIGHT_MULT*weight + ACCESS_WEIGHT*accesses
   localparam logic [7:0] W_LOGIC = 8'd1;
   localparam logic [7:0] W_ARITH = 8'd2;
   localparam logic [7:0] W_SHIFT = 8'd3;
   localparam int OPCODE_WEIGHT_MULT = 2;
   localparam int ACCESS_WEIGHT      = 4;

   function automatic decode_t decode_rtype(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic [6:0] funct7);
      decode_t d;
      d.legal = 1'b0;
      d.op    = ALU_ADD;
      if (opcode == OPCODE_RTYPE) begin
         case (funct3)
            F3_ADD_SUB: begin
               if (funct7 == F7_BASE) begin
                  d.legal = 1'b1; d.op = ALU_ADD;
               end else if (funct7 == F7_ALT) begin
                  d.legal = 1'b1; d.op = ALU_SUB;
               end
            end
            F3_SRL_SRA: begin
               if (funct7 == F7_BASE) begin
                  d.legal = 1'b1; d.op = ALU_SRL;
               end else if (funct7 == F7_ALT) begin
                  d.legal = 1'b1; d.op = ALU_SRA;
               end
            end
            F3_SLL:  begin d.legal = (funct7 == F7_BASE); d.op = ALU_SLL;  end
            F3_SLT:  begin d.legal = (funct7 == F7_BASE); d.op = ALU_SLT;  end
            F3_SLTU: begin d.legal = (funct7 == F7_BASE); d.op = ALU_SLTU; end
            F3_XOR:  begin d.legal = (funct7 == F7_BASE); d.op = ALU_XOR;  end
            F3_OR:   begin d.legal = (funct7 == F7_BASE); d.op = ALU_OR;   end
            F3_AND:  begin d.legal = (funct7 == F7_BASE); d.op = ALU_AND;  end
            default: begin d.legal = 1'b0; d.op = ALU_ADD; end
         endcase
      end
      return d;
   endfunction

   function automatic logic [7:0] op_weight(input alu_op_e op);
      case (op)
         ALU_AND, ALU_OR, ALU_XOR:  return W_LOGIC;
         ALU_SLL, ALU_SRL, ALU_SRA: return W_SHIFT;
         default:                   return W_ARITH;
      endcase
   endfunction

endpackage

// File: rtl/core_regfile.sv
// 32 x 32-bit integer register file for riscv_core.
// Ports:
//   clk_i, rst_i           clock (rising edge), asynchronous active-high reset
//   raddr1_i / rdata1_o    read port 1 (combinational)
//   raddr2_i / rdata2_o    read port 2 (combinational)
//   we_i, waddr_i, wdata_i synchronous write port
// x0 is hardwired to zero: writes to it are dropped and reads return 0.
module core_regfile
   import core_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] raddr1_i,
   output logic [XLEN-1:0]       rdata1_o,
   input  logic [REG_ADDR_W-1:0] raddr2_i,
   output logic [XLEN-1:0]       rdata2_o,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [XLEN-1:0]       wdata_i
);

   logic [XLEN-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
   assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/riscv_core.sv
// riscv_core: single-issue RV32I R-type execution core with register file,
// inline ALU and activity monitors (instruction/ALU/access counters,
// most-used register and ALU op, power estimate).
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   instruction, validInstruction   request in; sampled in IDLE
//   completeInstruction     one-cycle retire pulse
//   totalInstructions, totalOperationsALU, totalRegAccesses   32-bit wrapping counters
//   currentEstimatedPower   8-bit activity-based power estimate
//   mostUsedReg, mostUsedOpsALU     index of the most used register / ALU op
//   rs1Debug, rs2Debug, rdDebug, rsData1Debug, rsData2Debug, resultALUDebug
//                           fields, operands and result of the last instruction
// Build option: define CORE_POWER_EST_EN to include the power estimator;
// otherwise currentEstimatedPower is constant 0.
//
// Handshake: the requester raises validInstruction with a stable instruction
// and holds both until completeInstruction pulses. The core takes the request
// only in IDLE, and after retiring waits for validInstruction to go low before
// it will accept again, so a request that stays high executes exactly once.
// The FSM state is visible internally as state_q.
module riscv_core
   import core_pkg::*;
#(
   parameter int USAGE_CNT_W = 16,
   parameter int POWER_IDLE  = 5,
   parameter int POWER_BASE  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic        validInstruction,
   output logic        completeInstruction,
   output logic [31:0] totalInstructions,
   output logic [31:0] totalOperationsALU,
   output logic [31:0] totalRegAccesses,
   output logic [7:0]  currentEstimatedPower,
   output logic [4:0]  mostUsedReg,
   output logic [3:0]  mostUsedOpsALU,
   output logic [4:0]  rs1Debug,
   output logic [4:0]  rs2Debug,
   output logic [4:0]  rdDebug,
   output logic [31:0] rsData1Debug,
   output logic [31:0] rsData2Debug,
   output logic [31:0] resultALUDebug
);

   core_state_e state_q, state_d;

   decode_t               dec_q;
   logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
   logic [XLEN-1:0]       rs_data1_q, rs_data2_q, result_q;
   logic                  complete_q;
   logic [31:0]           total_instr_q, total_alu_q, total_acc_q;
   logic [REG_ADDR_W-1:0] most_reg_q, best_reg;
   logic [3:0]            most_op_q, best_op;

   logic [USAGE_CNT_W-1:0] reg_cnt_q [NUM_REGS];
   logic [USAGE_CNT_W-1:0] reg_cnt_d [NUM_REGS];
   logic [USAGE_CNT_W-1:0] op_cnt_q  [NUM_ALU_OPS];
   logic [USAGE_CNT_W-1:0] op_cnt_d  [NUM_ALU_OPS];
   logic [USAGE_CNT_W-1:0] best_reg_cnt, op_new_cnt, holder_op_cnt;

   logic [XLEN-1:0] rf_rdata1, rf_rdata2, alu_result;
   logic            rd_write;
   logic [1:0]      acc_cnt;
   decode_t         dec_in;

   function automatic logic [USAGE_CNT_W-1:0] sat_add(input logic [USAGE_CNT_W-1:0] cnt,
                                                      input logic [1:0] inc);
      logic [USAGE_CNT_W:0] sum;
      sum = {1'b0, cnt} + {{(USAGE_CNT_W-1){1'b0}}, inc};
      if (sum[USAGE_CNT_W]) return '1;
      return sum[USAGE_CNT_W-1:0];
   endfunction

   // ---------------- register file ----------------
   assign rd_write = dec_q.legal && (rd_q != '0);

   core_regfile u_regfile (
      .clk_i    (clk),
      .rst_i    (reset),
      .raddr1_i (instruction[19:15]),
      .rdata1_o (rf_rdata1),
      .raddr2_i (instruction[24:20]),
      .rdata2_o (rf_rdata2),
      .we_i     ((state_q == ST_WB) && rd_write),
      .waddr_i  (rd_q),
      .wdata_i  (result_q)
   );

   assign dec_in = decode_rtype(instruction[6:0], instruction[14:12], instruction[31:25]);

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (validInstruction) state_d = ST_EXEC;
         ST_EXEC:     state_d = ST_WB;
         ST_WB:       state_d = ST_WAIT_LOW;
         ST_WAIT_LOW: if (!validInstruction) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // ---------------- ALU ----------------
   // Illegal instructions produce 0 so nothing downstream sees stale data.
   always_comb begin
      alu_result = '0;
      if (dec_q.legal) begin
         case (dec_q.op)
            ALU_ADD:  alu_result = rs_data1_q + rs_data2_q;
            ALU_SUB:  alu_result = rs_data1_q - rs_data2_q;
            ALU_AND:  alu_result = rs_data1_q & rs_data2_q;
            ALU_OR:   alu_result = rs_data1_q | rs_data2_q;
            ALU_XOR:  alu_result = rs_data1_q ^ rs_data2_q;
            ALU_SLL:  alu_result = rs_data1_q << rs_data2_q[4:0];
            ALU_SRL:  alu_result = rs_data1_q >> rs_data2_q[4:0];
            ALU_SRA:  alu_result = $signed(rs_data1_q) >>> rs_data2_q[4:0];
            ALU_SLT:  alu_result = {31'd0, $signed(rs_data1_q) < $signed(rs_data2_q)};
            ALU_SLTU: alu_result = {31'd0, rs_data1_q < rs_data2_q};
            default:  alu_result = '0;
         endcase
      end
   end

   // ---------------- usage statistics ----------------
   assign acc_cnt = 2'(rs1_q != '0) + 2'(rs2_q != '0) + 2'(rd_write);

   // A register touched twice by one instruction (e.g. rs1 == rs2) counts twice.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_cnt_d[i] = sat_add(reg_cnt_q[i],
                                2'((rs1_q == 5'(i)) && (rs1_q != '0)) +
                                2'((rs2_q == 5'(i)) && (rs2_q != '0)) +
                                2'(rd_write && (rd_q == 5'(i))));
      end
   end

   // The holder's count is always the global maximum, so comparing the touched
   // registers against the holder's updated count gives strict-exceed with
   // ties going to the previous holder.
   always_comb begin
      best_reg     = most_reg_q;
      best_reg_cnt = reg_cnt_d[most_reg_q];
      if (reg_cnt_d[rs1_q] > best_reg_cnt) begin
         best_reg     = rs1_q;
         best_reg_cnt = reg_cnt_d[rs1_q];
      end
      if (reg_cnt_d[rs2_q] > best_reg_cnt) begin
         best_reg     = rs2_q;
         best_reg_cnt = reg_cnt_d[rs2_q];
      end
      if (reg_cnt_d[rd_q] > best_reg_cnt) begin
         best_reg     = rd_q;
         best_reg_cnt = reg_cnt_d[rd_q];
      end
   end

   always_comb begin
      op_new_cnt    = '0;
      holder_op_cnt = '0;
      for (int i = 0; i < NUM_ALU_OPS; i++) begin
         op_cnt_d[i] = op_cnt_q[i];
         if (dec_q.legal && (dec_q.op == alu_op_e'(i))) begin
            op_cnt_d[i] = sat_add(op_cnt_q[i], 2'd1);
            op_new_cnt  = op_cnt_d[i];
         end
         if (most_op_q == 4'(i)) holder_op_cnt = op_cnt_q[i];
      end
      best_op = most_op_q;
      if (dec_q.legal && (op_new_cnt > holder_op_cnt)) best_op = dec_q.op;
   end

   // ---------------- sequential state ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         dec_q         <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         rs_data1_q    <= '0;
         rs_data2_q    <= '0;
         result_q      <= '0;
         complete_q    <= 1'b0;
         total_instr_q <= '0;
         total_alu_q   <= '0;
         total_acc_q   <= '0;
         most_reg_q    <= '0;
         most_op_q     <= '0;
         for (int i = 0; i < NUM_REGS; i++)    reg_cnt_q[i] <= '0;
         for (int i = 0; i < NUM_ALU_OPS; i++) op_cnt_q[i]  <= '0;
      end else begin
         state_q    <= state_d;
         complete_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (validInstruction) begin
                  dec_q      <= dec_in;
                  rs1_q      <= instruction[19:15];
                  rs2_q      <= instruction[24:20];
                  rd_q       <= instruction[11:7];
                  rs_data1_q <= rf_rdata1;
                  rs_data2_q <= rf_rdata2;
               end
            end
            ST_EXEC: result_q <= alu_result;
            ST_WB: begin
               complete_q    <= 1'b1;
               total_instr_q <= total_instr_q + 32'd1;
               if (dec_q.legal) total_alu_q <= total_alu_q + 32'd1;
               total_acc_q   <= total_acc_q + 32'(acc_cnt);
               reg_cnt_q     <= reg_cnt_d;
               op_cnt_q      <= op_cnt_d;
               most_reg_q    <= best_reg;
               most_op_q     <= best_op;
            end
            default: ;
         endcase
      end
   end

   // ---------------- power estimate ----------------
`ifdef CORE_POWER_EST_EN
   logic [7:0] power_q, power_d;
   logic [9:0] power_raw;
   logic [7:0] weight;

   assign weight    = dec_q.legal ? op_weight(dec_q.op) : 8'd0;
   assign power_raw = 10'(POWER_BASE) + 10'(weight) * 10'(OPCODE_WEIGHT_MULT)
                    + 10'(acc_cnt) * 10'(ACCESS_WEIGHT);

   // Jumps to the activity value on retire, then bleeds down one step per
   // cycle to the idle floor (and is lifted to the floor if below it).
   always_comb begin
      power_d = power_q;
      if (state_q == ST_WB) begin
         power_d = (power_raw > 10'd255) ? 8'hFF : power_raw[7:0];
      end else if (power_q > 8'(POWER_IDLE)) begin
         power_d = power_q - 8'd1;
      end else begin
         power_d = 8'(POWER_IDLE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) power_q <= '0;
      else       power_q <= power_d;
   end

   assign currentEstimatedPower = power_q;
`else
   assign currentEstimatedPower = 8'd0;
`endif

   // ---------------- outputs ----------------
   assign completeInstruction = complete_q;
   assign totalInstructions   = total_instr_q;
   assign totalOperationsALU  = total_alu_q;
   assign totalRegAccesses    = total_acc_q;
   assign mostUsedReg         = most_reg_q;
   assign mostUsedOpsALU      = most_op_q;
   assign rs1Debug            = rs1_q;
   assign rs2Debug            = rs2_q;
   assign rdDebug             = rd_q;
   assign rsData1Debug        = rs_data1_q;
   assign rsData2Debug        = rs_data2_q;
   assign resultALUDebug      = result_q;

endmodule

// File: tb/tb_riscv_core.sv
module tb_riscv_core;

   localparam int USAGE_CNT_W = 16;
   localparam int POWER_IDLE  = 5;
   localparam int POWER_BASE  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic        valid;
   logic        complete;
   logic [31:0] tot_instr, tot_alu, tot_acc;
   logic [7:0]  power;
   logic [4:0]  most_reg;
   logic [3:0]  most_op;
   logic [4:0]  rs1_dbg, rs2_dbg, rd_dbg;
   logic [31:0] rs_data1_dbg, rs_data2_dbg, result_dbg;

   int          checks = 0;
   int          errors = 0;
   int          latency;
   int          extra_pulses;
   logic [7:0]  last_power;

   always #5 clk = ~clk;

   riscv_core #(
      .USAGE_CNT_W (USAGE_CNT_W),
      .POWER_IDLE  (POWER_IDLE),
      .POWER_BASE  (POWER_BASE)
   ) dut (
      .clk                   (clk),
      .reset                 (reset),
      .instruction           (instruction),
      .validInstruction      (valid),
      .completeInstruction   (complete),
      .totalInstructions     (tot_instr),
      .totalOperationsALU    (tot_alu),
      .totalRegAccesses      (tot_acc),
      .currentEstimatedPower (power),
      .mostUsedReg           (most_reg),
      .mostUsedOpsALU        (most_op),
      .rs1Debug              (rs1_dbg),
      .rs2Debug              (rs2_dbg),
      .rdDebug               (rd_dbg),
      .rsData1Debug          (rs_data1_dbg),
      .rsData2Debug          (rs_data2_dbg),
      .resultALUDebug        (result_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] pexp(input int v);
`ifdef CORE_POWER_EST_EN
      return 32'(v);
`else
      return 32'd0 + 32'(v - v);
`endif
   endfunction

   // Issue one request at a negedge, wait (bounded) for the retire pulse,
   // keep the request high for 'hold' more cycles, then drop it.
   task automatic run_instr(input logic [31:0] instr, input int hold);
      bit seen;
      int n;
      instruction = instr;
      valid       = 1'b1;
      seen        = 1'b0;
      n           = 0;
      while (!seen && n < 12) begin
         @(negedge clk);
         n++;
         if (complete === 1'b1) seen = 1'b1;
      end
      latency    = n;
      last_power = power;
      check("complete_seen", 32'(seen), 32'd1);
      extra_pulses = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (complete === 1'b1) extra_pulses++;
      end
      valid = 1'b0;
      @(negedge clk);
      if (complete === 1'b1) extra_pulses++;
      check("single_pulse", 32'(extra_pulses), 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      valid       = 1'b0;
      instruction = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_complete", 32'(complete), 32'd0);
      check("rst_tot_instr", tot_instr, 32'd0);
      check("rst_tot_alu", tot_alu, 32'd0);
      check("rst_tot_acc", tot_acc, 32'd0);
      check("rst_power", 32'(power), 32'd0);
      check("rst_most_reg", 32'(most_reg), 32'd0);
      check("rst_most_op", 32'(most_op), 32'd0);
      check("rst_result", result_dbg, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // 1: ADD x1,x0,x0
      run_instr(32'h000000B3, 0);
      check("t1_latency", 32'(latency), 32'd3);
      check("t1_rd", 32'(rd_dbg), 32'd1);
      check("t1_result", result_dbg, 32'd0);
      check("t1_tot_instr", tot_instr, 32'd1);
      check("t1_tot_alu", tot_alu, 32'd1);
      check("t1_tot_acc", tot_acc, 32'd1);
      check("t1_power", 32'(last_power), pexp(18));
      check("t1_most_reg", 32'(most_reg), 32'd1);

      // 2: ADD x3,x1,x2 ; SUB x4,x3,x1 ; AND x5,x2,x3
      run_instr(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0);
      check("t2a_rd", 32'(rd_dbg), 32'd3);
      check("t2a_tot_acc", tot_acc, 32'd4);
      run_instr(rtype(7'h20, 5'd1, 5'd3, 3'b000, 5'd4), 0);
      check("t2b_rd", 32'(rd_dbg), 32'd4);
      check("t2b_tot_acc", tot_acc, 32'd7);
      run_instr(rtype(7'h00, 5'd3, 5'd2, 3'b111, 5'd5), 0);
      check("t2c_rd", 32'(rd_dbg), 32'd5);
      check("t2c_result", result_dbg, 32'd0);
      check("t2c_tot_acc", tot_acc, 32'd10);
      check("t2c_tot_instr", tot_instr, 32'd4);
      check("t2c_power", 32'(last_power), pexp(24));
      check("t2c_most_reg", 32'(most_reg), 32'd1);

      // 3: backdoor operands, then arithmetic/compare/shift corner cases
      dut.u_regfile.regs_q[1]  = 32'd7;
      dut.u_regfile.regs_q[2]  = 32'd5;
      dut.u_regfile.regs_q[9]  = 32'h8000_0000;
      dut.u_regfile.regs_q[10] = 32'd4;
      run_instr(rtype(7'h20, 5'd1, 5'd2, 3'b000, 5'd6), 0);   // SUB x6,x2,x1
      check("t3_sub_rs1", 32'(rs1_dbg), 32'd2);
      check("t3_sub_rs2", 32'(rs2_dbg), 32'd1);
      check("t3_sub_data1", rs_data1_dbg, 32'd5);
      check("t3_sub_data2", rs_data2_dbg, 32'd7);
      check("t3_sub_result", result_dbg, 32'hFFFF_FFFE);
      run_instr(rtype(7'h00, 5'd1, 5'd2, 3'b010, 5'd7), 0);   // SLT x7,x2,x1
      check("t3_slt_result", result_dbg, 32'd1);
      run_instr(rtype(7'h00, 5'd1, 5'd6, 3'b011, 5'd8), 0);   // SLTU x8,x6,x1
      check("t3_sltu_data1", rs_data1_dbg, 32'hFFFF_FFFE);
      check("t3_sltu_result", result_dbg, 32'd0);
      run_instr(rtype(7'h20, 5'd10, 5'd9, 3'b101, 5'd11), 0); // SRA x11,x9,x10
      check("t3_sra_result", result_dbg, 32'hF800_0000);
      check("t3_sra_power", 32'(last_power), pexp(28));
      check("t3_tot_alu", tot_alu, 32'd8);
      check("t3_tot_acc", tot_acc, 32'd22);
      run_instr(rtype(7'h00, 5'd0, 5'd6, 3'b110, 5'd12), 0);  // OR x12,x6,x0
      check("t3_or_result", result_dbg, 32'hFFFF_FFFE);
      check("t3_or_tot_acc", tot_acc, 32'd24);

      // 4: request held high after retire executes once
      run_instr(rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd13), 5);  // ADD x13,x0,x0
      repeat (3) @(negedge clk);
      check("t4_tot_instr", tot_instr, 32'd10);
      check("t4_tot_alu", tot_alu, 32'd10);
      check("t4_tot_acc", tot_acc, 32'd25);

      // 5: illegal instructions retire without ALU count or writeback
      run_instr(32'h0000_0013, 0);
      check("t5_illegal_result", result_dbg, 32'd0);
      check("t5_illegal_tot_instr", tot_instr, 32'd11);
      check("t5_illegal_tot_alu", tot_alu, 32'd10);
      run_instr(rtype(7'h20, 5'd1, 5'd2, 3'b111, 5'd6), 0);   // bad funct7 on AND, rd=x6
      check("t5_badf7_result", result_dbg, 32'd0);
      check("t5_badf7_tot_alu", tot_alu, 32'd10);
      check("t5_badf7_tot_acc", tot_acc, 32'd27);
      run_instr(rtype(7'h00, 5'd0, 5'd6, 3'b110, 5'd12), 0);  // OR x12,x6,x0
      check("t5_x6_kept", rs_data1_dbg, 32'hFFFF_FFFE);
      check("t5_tot_alu", tot_alu, 32'd11);
      check("t5_most_reg", 32'(most_reg), 32'd1);
      check("t5_most_op", 32'(most_op), 32'd0);

      // 6: five XOR x5,x5,x5 -- ties keep the old holder, then x5/XOR take over
      for (int k = 1; k <= 5; k++) begin
         run_instr(rtype(7'h00, 5'd5, 5'd5, 3'b100, 5'd5), 0);
         if (k == 2) check("t6_tie_reg", 32'(most_reg), 32'd1);
         if (k == 3) begin
            check("t6_reg_takeover", 32'(most_reg), 32'd5);
            check("t6_tie_op", 32'(most_op), 32'd0);
         end
      end
      check("t6_most_op", 32'(most_op), 32'd4);
      check("t6_most_reg", 32'(most_reg), 32'd5);
      check("t6_power_peak", 32'(last_power), pexp(24));
      check("t6_tot_instr", tot_instr, 32'd18);
      check("t6_tot_alu", tot_alu, 32'd16);
      check("t6_tot_acc", tot_acc, 32'd44);
      repeat (20) @(negedge clk);
      check("t6_power_idle", 32'(power), pexp(POWER_IDLE));

      // Reset in the middle of an instruction aborts it
      instruction = rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd14);
      valid       = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_tot_instr", tot_instr, 32'd0);
      check("abort_tot_acc", tot_acc, 32'd0);
      check("abort_complete", 32'(complete), 32'd0);
      check("abort_most_reg", 32'(most_reg), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
